// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the FIFO drain stage.
package fifo_pkg;

    typedef enum logic {DRAIN_EMPTY, DRAIN_LOADED} drain_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: pops the FIFO into a one-stage valid/ready register and frames beats into fixed bursts.
// Optional stall counter output enabled by defining FIFO_BURST_DRAIN_STALL_CNT_EN.
module fifo_burst_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sop,
    output logic             o_eop
`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             load_ok, pop, last;

    // Next state: load on pop, otherwise release the register once the beat is taken
    always_comb begin
        load_ok = (state_q == DRAIN_EMPTY) || i_ready;
        pop     = load_ok && !i_fifo_empty && !i_rst;
        last    = cnt_q == LAST_BEAT;
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (pop) begin
            state_d = DRAIN_LOADED;
            data_d  = i_fifo_data;
            sop_d   = cnt_q == '0;
            eop_d   = last;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end else if (state_q == DRAIN_LOADED && i_ready) begin
            state_d = DRAIN_EMPTY;
        end
    end

    // Output register, beat counter and state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= DRAIN_EMPTY;
            cnt_q   <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign o_fifo_rd_en = pop;
    assign o_valid      = state_q == DRAIN_LOADED;
    assign o_data       = data_q;
    assign o_sop        = sop_q;
    assign o_eop        = eop_q;

`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles the downstream holds off a valid beat
    always_comb begin
        stall_d = (o_valid && !i_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`endif

    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        o_fifo_rd_en |-> !i_fifo_empty);

    a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_sop) && $stable(o_eop)));

    a_marks_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_sop && o_eop));

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: randomized and directed checks of fifo_burst_drain against a burst-position scoreboard.
module tb_fifo_burst_drain;

    localparam int W  = 4;
    localparam int BL = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
        logic         e;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         rd_en;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         o_sop;
    logic         o_eop;
`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
    logic [15:0]  o_stall_cnt;
`endif

    logic [W-1:0] mem [0:255];
    logic [7:0]   rd = 8'd0;
    logic [7:0]   wr = 8'd0;

    beat_t exp_q[$];
    int    acc_t[$];
    int    nb = 0;
    int    total = 0;
    int    bad = 0;
    int    npop = 0;
    int    cyc = 0;
    int    stall_m = 0;
    logic  held = 1'b0;
    beat_t held_b;

    fifo_burst_drain #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_fifo_data(fifo_data),
        .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd_en),
        .o_valid(o_valid),
        .i_ready(ready),
        .o_data(o_data),
        .o_sop(o_sop),
        .o_eop(o_eop)
`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = rd == wr;
    assign fifo_data  = mem[rd];

    always @(posedge clk or posedge rst) begin
        if (rst) rd <= wr;
        else if (rd_en) rd <= rd + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        mem[wr] = w;
        wr = wr + 8'd1;
        exp_q.push_back(beat_t'{d: w, s: (nb % BL) == 0, e: (nb % BL) == BL - 1});
        nb++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        nb = 0;
        stall_m = 0;
        held = 1'b0;
        #1;
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_sop", o_sop, 0);
        check_eq("rst_eop", o_eop, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_rd_en", rd_en, 0);
`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
        check_eq("rst_stall_cnt", o_stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            check_eq("rd_en_while_empty", rd_en & fifo_empty, 0);
            check_eq("sop_and_eop", o_valid & o_sop & o_eop, 0);
            if (held) begin
                check_eq("hold_valid", o_valid, 1);
                check_eq("hold_beat", {o_data, o_sop, o_eop}, held_b);
            end
`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
            check_eq("stall_cnt", o_stall_cnt, stall_m);
            if (o_valid && !ready && stall_m < 16'hFFFF) stall_m++;
`endif
            if (rd_en) npop++;
            if (o_valid && ready) begin
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_eq("beat_data", o_data, b.d);
                    check_eq("beat_sop", o_sop, b.s);
                    check_eq("beat_eop", o_eop, b.e);
                    acc_t.push_back(cyc);
                end
            end
            held   = o_valid && !ready;
            held_b = {o_data, o_sop, o_eop};
        end
    end

    initial begin
        int n0, snap, p0;
        logic [7:0] occ;
        do_reset();

        // streaming at full throughput
        @(posedge clk);
        #1;
        ready = 1'b1;
        n0 = acc_t.size();
        snap = cyc;
        for (int i = 1; i <= 8; i++) push(W'(i));
        repeat (12) @(posedge clk);
        #1;
        check_eq("stream_count", acc_t.size() - n0, 8);
        if (acc_t.size() - n0 >= 8) begin
            check_eq("stream_latency", acc_t[n0] - snap, 2);
            check_eq("stream_span", acc_t[n0 + 7] - acc_t[n0], 7);
        end

        // backpressure holds the first beat
        ready = 1'b0;
        p0 = npop;
        for (int i = 0; i < 4; i++) push(W'(4'hA + i));
        repeat (6) @(posedge clk);
        #1;
        check_eq("bp_single_pop", npop - p0, 1);
        check_eq("bp_valid", o_valid, 1);
        check_eq("bp_data", o_data, 4'hA);
        check_eq("bp_sop", o_sop, 1);
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("bp_drained", exp_q.size(), 0);

        // empty FIFO never pops
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            ready = 1'($urandom);
            @(negedge clk);
            check_eq("empty_valid", o_valid, 0);
            check_eq("empty_rd_en", rd_en, 0);
        end

        // gap inside a burst keeps the beat position
        @(posedge clk);
        #1;
        ready = 1'b1;
        push(4'h3);
        push(4'h4);
        repeat (6) @(posedge clk);
        #1;
        push(4'h5);
        push(4'h6);
        repeat (5) @(posedge clk);
        #1;
        check_eq("gap_drained", exp_q.size(), 0);

        // reset mid-burst with words queued
        ready = 1'b0;
        push(4'h1);
        push(4'h2);
        push(4'h7);
        repeat (2) @(posedge clk);
        #1;
        check_eq("pre_rst_valid", o_valid, 1);
        do_reset();
        @(posedge clk);
        #1;
        check_eq("post_rst_empty", fifo_empty, 1);
        ready = 1'b1;
        push(4'h9);
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_drained", exp_q.size(), 0);

`ifdef FIFO_BURST_DRAIN_STALL_CNT_EN
        do_reset();
        @(posedge clk);
        #1;
        ready = 1'b0;
        push(4'hC);
        repeat (11) @(posedge clk);
        #1;
        check_eq("stall_ten", o_stall_cnt, 10);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();
`endif

        // random traffic with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            @(posedge clk);
            #1;
            ready = $urandom_range(0, 3) != 0;
            occ = wr - rd;
            if (occ < 8'd12 && $urandom_range(0, 2) != 0) push(W'($urandom));
        end
        @(posedge clk);
        #1;
        ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_eq("final_drained", exp_q.size(), 0);
        check_eq("final_fifo_empty", fifo_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
